// File: rtl/apb_wait_slave.sv
// APB slave with a word-addressed register file and a fixed number of wait
// states per transfer. Two-state FSM (IDLE/ACCESS); all responses registered.
//
// Handshake: a transfer starts with a setup phase (PSEL=1, PENABLE=0) sampled
// in IDLE. The access phase holds PSEL=1 and PENABLE=1 until PREADY=1 is seen
// on a rising PCLK edge. That edge completes the transfer. PRDATA and PSLVERR
// are only meaningful while PREADY=1. Dropping PSEL during the access phase
// aborts the transfer and commits nothing.
module apb_wait_slave #(
  parameter int ADDWIDTH    = 8,
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDWIDTH-1:0]    PADDR,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR,
  output logic                   dbg_state
);

  localparam int NB   = DATAWIDTH / 8;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDWIDTH-1:0]   addr_l;
  logic                  wr_l;
  logic [DATAWIDTH-1:0]  wdata_l;
  logic [NB-1:0]         strb_l;
  logic                  err_l;

  logic [DATAWIDTH-1:0]  mem [DEPTH];

  logic                  setup;
  logic                  setup_err;
  logic [DATAWIDTH-1:0]  setup_rd;
  logic [DATAWIDTH-1:0]  acc_rd;
  logic                  complete;
  logic                  commit;

  // Out-of-range addresses are flagged at setup time and never touch storage.
  assign setup     = PSEL && !PENABLE;
  assign setup_err = (32'(PADDR) >= DEPTH);
  assign setup_rd  = (PWRITE || setup_err) ? '0 : mem[PADDR[IDXW-1:0]];
  assign acc_rd    = (wr_l || err_l) ? '0 : mem[addr_l[IDXW-1:0]];
  assign complete  = (state == ACCESS) && PSEL && PENABLE && PREADY;
  assign commit    = complete && wr_l && !err_l;
  assign dbg_state = state;

  // Transfer FSM: latches the request, counts wait states, drives responses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_l  <= '0;
      wr_l    <= 1'b0;
      wdata_l <= '0;
      strb_l  <= '0;
      err_l   <= 1'b0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state   <= ACCESS;
            addr_l  <= PADDR;
            wr_l    <= PWRITE;
            wdata_l <= PWDATA;
            strb_l  <= PSTRB;
            err_l   <= setup_err;
            cnt     <= 4'(WAIT_CYCLES);
            PREADY  <= (WAIT_CYCLES == 0);
            // With no wait states the response is due in the first access cycle.
            if (WAIT_CYCLES == 0) begin
              PSLVERR <= setup_err;
              PRDATA  <= setup_rd;
            end
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else if (PENABLE && !PREADY) begin
            cnt    <= cnt - 4'd1;
            PREADY <= (cnt == 4'd1);
            if (cnt == 4'd1) begin
              PSLVERR <= err_l;
              PRDATA  <= acc_rd;
            end
          end else if (PENABLE && PREADY) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: cleared by reset, byte-merged write on a successful completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_l[b]) mem[addr_l[IDXW-1:0]][8*b +: 8] <= wdata_l[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance on a shared APB bus, selected by sel_b.
module tb_apb_wait_slave;

  localparam int WAIT_A = 2;

  // clock / reset
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic presetn;

  logic        psel, penable, pwrite, sel_b;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        psel_a, psel_b;
  logic        pready_a, pslverr_a, st_a;
  logic        pready_b, pslverr_b, st_b;
  logic [31:0] prdata_a, prdata_b;
  logic        m_pready, m_pslverr, m_st;
  logic [31:0] m_prdata;

  assign psel_a    = psel & ~sel_b;
  assign psel_b    = psel & sel_b;
  assign m_pready  = sel_b ? pready_b  : pready_a;
  assign m_pslverr = sel_b ? pslverr_b : pslverr_a;
  assign m_prdata  = sel_b ? prdata_b  : prdata_a;
  assign m_st      = sel_b ? st_b      : st_a;

  apb_wait_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .DEPTH(16), .WAIT_CYCLES(WAIT_A)) dut_a (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready_a), .PRDATA(prdata_a),
    .PSLVERR(pslverr_a), .dbg_state(st_a));

  apb_wait_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready_b), .PRDATA(prdata_b),
    .PSLVERR(pslverr_b), .dbg_state(st_b));

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [16];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; drives setup immediately, returns #1 after the
  // falling edge of the PREADY cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic [32:0] e;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge pclk);
    penable = 1'b1;
    // Latched fields must be immune to later bus changes.
    paddr  = 8'($urandom_range(0, 255));
    pwdata = $urandom;
    pstrb  = 4'($urandom_range(0, 15));
    pwrite = 1'($urandom_range(0, 1));
    lat = 1;
    #1;
    while (!m_pready && lat < 20) begin
      check("prdata_zero_in_wait", m_prdata, 0);
      @(negedge pclk);
      lat++;
      #1;
    end
    e = exp_q.pop_front();
    if (!m_pready) begin
      check("pready_timeout", m_pready, 1);
    end else begin
      check("latency", lat, sel_b ? 1 : WAIT_A + 1);
      check("prdata", m_prdata, e[31:0]);
      check("pslverr", m_pslverr, e[32]);
    end
  endtask

  task automatic idle_check();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    #1;
    check("idle_pready", m_pready, 0);
    check("idle_prdata", m_prdata, 0);
    check("idle_pslverr", m_pslverr, 0);
    check("idle_state", m_st, 0);
  endtask

  task automatic merge(input int a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'd0,  32'hCAFEBABE, 4'b1111, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 8'd0,  32'h0,        4'b1111, 32'hCAFEBABE, 1'b0};
    vecs[2]  = '{1'b1, 8'd1,  32'hFFFFFFFF, 4'b1010, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 8'd1,  32'h00EE00EE, 4'b0101, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 8'd1,  32'h0,        4'b1111, 32'hFFEEFFEE, 1'b0};
    vecs[5]  = '{1'b0, 8'd0,  32'h0,        4'b0000, 32'hCAFEBABE, 1'b0};
    vecs[6]  = '{1'b1, 8'd20, 32'h12345678, 4'b1111, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 8'd20, 32'h0,        4'b1111, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 8'd15, 32'h11223344, 4'b1111, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 8'd15, 32'h0,        4'b1111, 32'h11223344, 1'b0};
    vecs[10] = '{1'b1, 8'd16, 32'h55555555, 4'b1111, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 8'd4,  32'h0,        4'b1111, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 8'd0,  32'h0,        4'b1111, 32'hCAFEBABE, 1'b0};

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel_b = 1'b0;
    #12;
    check("rst_pready_a", pready_a, 0);
    check("rst_prdata_a", prdata_a, 0);
    check("rst_pslverr_a", pslverr_a, 0);
    check("rst_state_a", st_a, 0);
    check("rst_pready_b", pready_b, 0);
    check("rst_state_b", st_b, 0);

    // Release reset on a falling edge; first setup lands on the next edge.
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge pclk);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_rd, vecs[i].exp_err);
    end
    idle_check();

    // Random byte-merged writes to addrs 5..14, then read them back.
    for (int a = 0; a < 16; a++) model[a] = '0;
    model[0] = 32'hCAFEBABE; model[1] = 32'hFFEEFFEE; model[15] = 32'h11223344;
    for (int k = 0; k < 12; k++) begin
      int a;
      logic [31:0] d;
      logic [3:0] s;
      a = $urandom_range(5, 14);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      merge(a, d, s);
      @(negedge pclk);
      xfer(1'b1, 8'(a), d, s, 32'h0, 1'b0);
    end
    for (int a = 5; a < 15; a++) begin
      @(negedge pclk);
      xfer(1'b0, 8'(a), 32'h0, 4'hF, model[a], 1'b0);
    end
    idle_check();

    // PSEL+PENABLE in IDLE without a setup phase is ignored.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd6; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      #1;
      check("noset_pready", m_pready, 0);
      check("noset_state", m_st, 0);
    end
    idle_check();
    @(negedge pclk);
    xfer(1'b0, 8'd6, 32'h0, 4'hF, model[6], 1'b0);
    idle_check();

    // Abort: PSEL dropped during the wait on a write to addr 3.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    #1;
    check("abort_state", m_st, 0);
    check("abort_pready", m_pready, 0);
    @(negedge pclk);
    xfer(1'b0, 8'd3, 32'h0, 4'hF, 32'h0, 1'b0);
    idle_check();

    // Reset pulsed during the PREADY cycle of a read of addr 0.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    #1;
    check("pre_rst_pready", m_pready, 1);
    check("pre_rst_prdata", m_prdata, 32'hCAFEBABE);
    #2;
    presetn = 1'b0;
    #1;
    check("async_rst_pready", m_pready, 0);
    check("async_rst_prdata", m_prdata, 0);
    check("async_rst_pslverr", m_pslverr, 0);
    check("async_rst_state", m_st, 0);
    @(negedge pclk);
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 8'd0, 32'h0, 4'hF, 32'h0, 1'b0);
    @(negedge pclk);
    xfer(1'b0, 8'd1, 32'h0, 4'hF, 32'h0, 1'b0);
    idle_check();

    // Zero-wait instance: back-to-back strobed writes, read, error read.
    @(negedge pclk);
    sel_b = 1'b1;
    xfer(1'b1, 8'd2, 32'hDEAD1234, 4'b1100, 32'h0, 1'b0);
    @(negedge pclk);
    xfer(1'b1, 8'd2, 32'h5678CAFE, 4'b0011, 32'h0, 1'b0);
    @(negedge pclk);
    xfer(1'b0, 8'd2, 32'h0, 4'hF, 32'hDEADCAFE, 1'b0);
    @(negedge pclk);
    xfer(1'b0, 8'd200, 32'h0, 4'hF, 32'h0, 1'b1);
    idle_check();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
